// File: rtl/rf_riscv_sb.sv
// Register file with NREAD combinational read ports, primary and late write ports, and a busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_WRITE_BYPASS_EN.
module rf_riscv_sb #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int NREAD = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   lwe_i,
  input  logic [AW-1:0]          lwaddr_i,
  input  logic [WIDTH-1:0]       lwdata_i,
  input  logic                   rsv_i,
  input  logic [AW-1:0]          rsv_addr_i,
  input  logic [NREAD*AW-1:0]    raddr_i,
  output logic [NREAD*WIDTH-1:0] rdata_o,
  output logic [NREAD-1:0]       rbusy_o,
  output logic [CW-1:0]          pend_cnt_o,
  output logic                   wr_conflict_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [CW-1:0]    pend;
  logic             conflict;
  logic             rsv_hit;
  logic             rel_hit;
  logic             inc;
  logic             dec;
  logic             conflict_next;

  // Entry 0 is only ever reset, so it stays zero; primary wins a same-address collision.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (we_i && (waddr_i == AW'(i))) begin
          mem[i] <= wdata_i;
        end else if (lwe_i && (lwaddr_i == AW'(i))) begin
          mem[i] <= lwdata_i;
        end
      end
    end
  end

  always_comb begin
    busy_next = busy;
    for (int i = 1; i < DEPTH; i++) begin
      if (rsv_i && (rsv_addr_i == AW'(i))) begin
        busy_next[i] = 1'b1;
      end else if (lwe_i && (lwaddr_i == AW'(i))) begin
        busy_next[i] = 1'b0;
      end
    end
    busy_next[0] = 1'b0;
  end

  // A new reservation overrides a same-register release, so that release does not decrement.
  assign rsv_hit       = rsv_i && (rsv_addr_i != '0);
  assign rel_hit       = lwe_i && (lwaddr_i != '0);
  assign inc           = rsv_hit && !busy[rsv_addr_i];
  assign dec           = rel_hit && busy[lwaddr_i] && !(rsv_hit && (rsv_addr_i == lwaddr_i));
  assign conflict_next = we_i && lwe_i && (waddr_i == lwaddr_i) && (waddr_i != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy     <= '0;
      pend     <= '0;
      conflict <= 1'b0;
    end else begin
      busy     <= busy_next;
      conflict <= conflict_next;
      case ({inc, dec})
        2'b10:   pend <= pend + CW'(1);
        2'b01:   pend <= pend - CW'(1);
        default: pend <= pend;
      endcase
    end
  end

  assign pend_cnt_o    = pend;
  assign wr_conflict_o = conflict;

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             bsy;

    assign addr = raddr_i[k*AW +: AW];

    always_comb begin
      data = mem[addr];
      bsy  = busy[addr];
`ifdef RF_WRITE_BYPASS_EN
      if (addr != '0) begin
        if (we_i && (waddr_i == addr)) begin
          data = wdata_i;
        end else if (lwe_i && (lwaddr_i == addr)) begin
          data = lwdata_i;
        end
        if (lwe_i && (lwaddr_i == addr) && !(rsv_i && (rsv_addr_i == addr))) begin
          bsy = 1'b0;
        end
      end
`endif
      if (addr == '0) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rdata_o[k*WIDTH +: WIDTH] = data;
    assign rbusy_o[k]                = bsy;
  end

endmodule

// File: tb/tb_rf_riscv_sb.sv
// Self-checking bench for rf_riscv_sb: a vector table fed through a scoreboard queue, plus
// hand-written sequences for same-cycle reads, the reserve sweep and asynchronous reset.
module tb_rf_riscv_sb;
  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
  localparam int CW    = 6;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   we = 1'b0;
  logic [AW-1:0]          waddr = '0;
  logic [WIDTH-1:0]       wdata = '0;
  logic                   lwe = 1'b0;
  logic [AW-1:0]          lwaddr = '0;
  logic [WIDTH-1:0]       lwdata = '0;
  logic                   rsv = 1'b0;
  logic [AW-1:0]          rsv_addr = '0;
  logic [AW-1:0]          ra0 = '0;
  logic [AW-1:0]          ra1 = '0;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*WIDTH-1:0] rdata;
  logic [NREAD-1:0]       rbusy;
  logic [CW-1:0]          pend_cnt;
  logic                   wr_conflict;

  int total_count = 0;
  int pass_count  = 0;

  assign raddr = {ra1, ra0};

  always #5 clk = ~clk;

  rf_riscv_sb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NREAD(NREAD)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .lwe_i(lwe), .lwaddr_i(lwaddr), .lwdata_i(lwdata),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .pend_cnt_o(pend_cnt), .wr_conflict_o(wr_conflict)
  );

  typedef struct {
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             lwe;
    logic [AW-1:0]    lwaddr;
    logic [WIDTH-1:0] lwdata;
    logic             rsv;
    logic [AW-1:0]    rsv_addr;
    logic [AW-1:0]    ra0;
    logic [AW-1:0]    ra1;
    logic [WIDTH-1:0] exp_d0;
    logic [WIDTH-1:0] exp_d1;
    logic             exp_b0;
    logic             exp_b1;
    logic [CW-1:0]    exp_pend;
    logic             exp_conf;
  } vec_t;

  vec_t vecs[12];
  vec_t sb_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_ports(input string tag, input logic [31:0] d0, input logic b0,
                             input logic [31:0] d1, input logic b1);
    check_output({tag, " rdata0"}, rdata[0 +: WIDTH], d0);
    check_output({tag, " rbusy0"}, 32'(rbusy[0]), 32'(b0));
    check_output({tag, " rdata1"}, rdata[WIDTH +: WIDTH], d1);
    check_output({tag, " rbusy1"}, 32'(rbusy[1]), 32'(b1));
  endtask

  // Drives one cycle of writes/reservation; enables drop #1 after the edge so reads show stored state.
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    we = v.we; waddr = v.waddr; wdata = v.wdata;
    lwe = v.lwe; lwaddr = v.lwaddr; lwdata = v.lwdata;
    rsv = v.rsv; rsv_addr = v.rsv_addr;
    ra0 = v.ra0; ra1 = v.ra1;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    we = 1'b0; lwe = 1'b0; rsv = 1'b0;
  endtask

  task automatic compare_result(input int idx);
    vec_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (sb_q.size() == 0) begin
      total_count++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    #1;
    check_ports(tag, e.exp_d0, e.exp_b0, e.exp_d1, e.exp_b1);
    check_output({tag, " pend"}, 32'(pend_cnt), 32'(e.exp_pend));
    check_output({tag, " conflict"}, 32'(wr_conflict), 32'(e.exp_conf));
  endtask

  initial begin
    logic [WIDTH-1:0] exp_d;
    logic             exp_b;

    //          we wa wdata          lwe la lwdata     rsv ra  r0  r1  exp_d0         exp_d1         b0 b1 pend conf
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0,  0, 32'h0,     0,  0,  5,  0,  32'hDEADBEEF,  32'h0,         0, 0, 0,   0};
    vecs[1]  = '{1, 0, 32'h1234,     1,  0, 32'h5678,  1,  0,  0,  5,  32'h0,         32'hDEADBEEF,  0, 0, 0,   0};
    vecs[2]  = '{0, 0, 32'h0,        0,  0, 32'h0,     1,  7,  7,  7,  32'h0,         32'h0,         1, 1, 1,   0};
    vecs[3]  = '{1, 7, 32'hA,        0,  0, 32'h0,     0,  0,  7,  5,  32'hA,         32'hDEADBEEF,  1, 0, 1,   0};
    vecs[4]  = '{0, 0, 32'h0,        1,  7, 32'hB,     0,  0,  7,  7,  32'hB,         32'hB,         0, 0, 0,   0};
    vecs[5]  = '{1, 9, 32'h11,       1,  9, 32'h22,    0,  0,  9,  7,  32'h11,        32'hB,         0, 0, 0,   1};
    vecs[6]  = '{0, 0, 32'h0,        0,  0, 32'h0,     0,  0,  9,  9,  32'h11,        32'h11,        0, 0, 0,   0};
    vecs[7]  = '{0, 0, 32'h0,        0,  0, 32'h0,     1,  3,  3,  9,  32'h0,         32'h11,        1, 0, 1,   0};
    vecs[8]  = '{0, 0, 32'h0,        1,  3, 32'h33,    1,  3,  3,  3,  32'h33,        32'h33,        1, 1, 1,   0};
    vecs[9]  = '{0, 0, 32'h0,        0,  0, 32'h0,     1,  4,  4,  3,  32'h0,         32'h33,        1, 1, 2,   0};
    vecs[10] = '{1, 10, 32'h77,      1, 11, 32'h88,    1, 12, 10, 11,  32'h77,        32'h88,        0, 0, 3,   0};
    vecs[11] = '{0, 0, 32'h0,        1,  3, 32'h44,    0,  0,  3, 12,  32'h44,        32'h0,         0, 1, 2,   0};

    $display("[TB] reset state sweep");
    #2;
    for (int a = 0; a < DEPTH; a++) begin
      ra0 = AW'(a); ra1 = AW'(DEPTH - 1 - a);
      #1;
      check_ports($sformatf("reset a%0d", a), 32'h0, 1'b0, 32'h0, 1'b0);
    end
    check_output("reset pend", 32'(pend_cnt), 32'h0);
    check_output("reset conflict", 32'(wr_conflict), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      compare_result(i);
    end

    // Late write to busy x4 alongside a discarded primary write to x0, sampled before the edge.
    $display("[TB] same-cycle late write");
    @(negedge clk);
    lwe = 1'b1; lwaddr = 5'd4; lwdata = 32'h55;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF;
    ra0 = 5'd4; ra1 = 5'd0;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check_ports("bypass x4 pre", 32'h55, 1'b0, 32'h0, 1'b0);
`else
    check_ports("nobypass x4 pre", 32'h0, 1'b1, 32'h0, 1'b0);
`endif
    @(posedge clk);
    #1;
    we = 1'b0; lwe = 1'b0;
    #1;
    check_ports("x4 post", 32'h55, 1'b0, 32'h0, 1'b0);
    check_output("x4 post pend", 32'(pend_cnt), 32'd1);

    // Both ports plus a reservation on busy x12: primary data, still busy, conflict pulse.
    $display("[TB] same-cycle collision with reservation");
    @(negedge clk);
    we = 1'b1; waddr = 5'd12; wdata = 32'hF00D;
    lwe = 1'b1; lwaddr = 5'd12; lwdata = 32'hC0C0;
    rsv = 1'b1; rsv_addr = 5'd12;
    ra0 = 5'd12; ra1 = 5'd4;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    exp_d = 32'hF00D;
`else
    exp_d = 32'h0;
`endif
    exp_b = 1'b1;
    check_ports("x12 pre", exp_d, exp_b, 32'h55, 1'b0);
    @(posedge clk);
    #1;
    we = 1'b0; lwe = 1'b0; rsv = 1'b0;
    #1;
    check_ports("x12 post", 32'hF00D, 1'b1, 32'h55, 1'b0);
    check_output("x12 post pend", 32'(pend_cnt), 32'd1);
    check_output("x12 conflict", 32'(wr_conflict), 32'd1);
    @(posedge clk);
    #2;
    check_output("x12 conflict drop", 32'(wr_conflict), 32'd0);

    // x12 is already busy, so it does not add to the count when swept.
    $display("[TB] reserve sweep");
    for (int a = 1; a < DEPTH; a++) begin
      @(negedge clk);
      rsv = 1'b1; rsv_addr = AW'(a);
      @(posedge clk);
      #1;
      rsv = 1'b0;
      check_output($sformatf("sweep pend a%0d", a), 32'(pend_cnt), 32'(a + ((a < 12) ? 1 : 0)));
    end
    ra0 = 5'd31; ra1 = 5'd9;
    #1;
    check_ports("sweep busy", 32'h0, 1'b1, 32'h11, 1'b1);

    $display("[TB] asynchronous reset mid-cycle");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midreset pend", 32'(pend_cnt), 32'h0);
    check_output("midreset conflict", 32'(wr_conflict), 32'h0);
    for (int a = 0; a < DEPTH; a++) begin
      ra0 = AW'(a); ra1 = AW'(DEPTH - 1 - a);
      #0.1;
      check_ports($sformatf("midreset a%0d", a), 32'h0, 1'b0, 32'h0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/rf_riscv_sb.md
Name: rf_riscv_sb

Overview:
- Parametrised successor register file for the RISC-V core.
- Has NREAD combinational read ports and two write ports:
  - primary port for execute writeback;
  - late port for load/multi-cycle writeback.
- Holds a per-register busy scoreboard: issue reserves a destination, the late write releases it.
- Sits between decode (reads, reservations) and the writeback stage. Hazard logic uses the busy flags and the pending count to stall.

Parameters:
- DEPTH, 32, number of architectural registers; power of two, at least 2.
- WIDTH, 32, data width in bits.
- NREAD, 2, number of read ports, 1 to 4.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- we_i  in  1  primary write enable.
- waddr_i  in  AW  primary write address.
- wdata_i  in  WIDTH  primary write data.
- lwe_i  in  1  late write enable; also releases the reservation.
- lwaddr_i  in  AW  late write address.
- lwdata_i  in  WIDTH  late write data.
- rsv_i  in  1  reserve request for rsv_addr_i.
- rsv_addr_i  in  AW  register to mark busy.
- raddr_i  in  NREAD*AW  packed read addresses; port k is at bits [k*AW +: AW].
- rdata_o  out  NREAD*WIDTH  packed read data.
- rbusy_o  out  NREAD  per-port busy flag of the addressed register.
- pend_cnt_o  out  $clog2(DEPTH+1)  number of registers currently busy.
- wr_conflict_o  out  1  registered pulse when both write ports hit the same nonzero address.

Behaviour:
- Reset (rst_i low, asynchronous, no clock required):
  - all DEPTH entries become 0;
  - all busy bits become 0;
  - pend_cnt_o becomes 0;
  - wr_conflict_o becomes 0.
- rdata_o and rbusy_o are combinational, so they read 0 during and after reset.
- Register 0 is hardwired:
  - reads of address 0 always return 0 with busy 0;
  - writes to 0 are discarded;
  - rsv_i with address 0 is ignored and does not change pend_cnt_o.
- Writes commit on the rising edge; read latency is 0 (combinational).
- Write port collision: both enables high with waddr_i == lwaddr_i != 0.
  - The primary port data is stored.
  - The late port still releases the busy bit.
  - wr_conflict_o is 1 for exactly the next cycle.
- Busy update per cycle, for address a:
  - set if rsv_i and rsv_addr_i == a;
  - else clear if lwe_i and lwaddr_i == a;
  - else hold.
  - Reserve and release of the same register in the same cycle leaves it busy (the new reservation wins).
- A primary write to a busy register updates the data and leaves busy unchanged.
- Reserving an already-busy register leaves it busy; pend_cnt_o is unchanged.
- pend_cnt_o: registered, equal to the population count of the busy bits after each edge.
  - Implement as an increment/decrement counter.
  - Net change per cycle is -1, 0 or +1.
  - Never exceeds DEPTH-1 and never wraps.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- Reads on multiple ports of the same address return identical data and busy.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined:
  - A read whose address matches a same-cycle write returns that write data combinationally.
  - Primary takes priority over late when both match.
  - A late-write match also forces that port's rbusy_o to 0, unless the same register is being reserved that cycle.
  - Address 0 is never bypassed.
- Not defined:
  - Reads return only stored contents.
  - rbusy_o reflects the stored busy bits.
  - Write-then-read needs one cycle.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rdata is 0, rbusy_o=0, pend_cnt_o=0. Release rst_i, write 0xDEADBEEF to x5 via the primary port -> next cycle reading x5 gives 0xDEADBEEF.
- Primary write 0x1234 to x0, late write 0x5678 to x0, rsv x0 -> x0 reads 0, pend_cnt_o stays 0, wr_conflict_o stays 0.
- rsv x7 -> rbusy=1, pend_cnt_o=1.
  - Primary write 0xA to x7 -> data 0xA, still busy.
  - Late write 0xB to x7 -> data 0xB, busy 0, pend_cnt_o=0.
- Same cycle:
  - primary 0x11 and late 0x22 to x9 -> x9=0x11, wr_conflict_o=1 for one cycle;
  - rsv x3 with late write to x3 -> x3 stays busy, count unchanged.
- With RF_WRITE_BYPASS_EN, late write 0x55 to busy x4 while reading x4 -> same-cycle rdata=0x55, rbusy=0. Without the macro -> old data and rbusy=1 that cycle; 0x55 and 0 the next cycle.
- Reserve x1..x31 over 31 cycles -> pend_cnt_o=31. Assert rst_i mid-sequence between clock edges -> immediate pend_cnt_o=0, all busy 0, all data 0.
